// File: rtl/pong_pkg.sv
// Shared types and constants for the BASPONG match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_PAUSE = 3'd4,
    ST_OVER  = 3'd5
  } match_state_t;

  localparam logic [7:0] CMD_PAUSE   = 8'h70;
  localparam logic [7:0] CMD_RESTART = 8'h72;
  localparam logic [7:0] CMD_SERVE   = 8'h73;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_TOP  = 2'b01;
  localparam logic [1:0] WIN_BOT  = 2'b10;

endpackage

// File: rtl/score_bcd_counter.sv
// Two-digit BCD score counter; at_limit flags that the next increment reaches LIMIT.
module score_bcd_counter #(
  parameter int LIMIT = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       at_limit
);

  localparam logic [3:0] LIM_TENS = 4'(LIMIT / 10);
  localparam logic [3:0] LIM_ONES = 4'(LIMIT % 10);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] inc_ones, inc_tens;

  always_comb begin
    inc_ones = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
    inc_tens = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc) begin
      ones_d = inc_ones;
      tens_d = inc_tens;
    end
    // Looking at the incremented value lets the FSM choose OVER in the same cycle.
    at_limit = (inc_ones == LIM_ONES) && (inc_tens == LIM_TENS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/match_sequencer.sv
// BASPONG game-flow controller: match FSM, point edge detection and BCD scores.
module match_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = 11,
  parameter int POINT_PAUSE_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       start_ball,
  input  logic       score_top,
  input  logic       score_bot,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       ball_run,
  output logic       ball_hold,
  output logic       paddle_en,
  output logic [3:0] top_ones,
  output logic [3:0] top_tens,
  output logic [3:0] bot_ones,
  output logic [3:0] bot_tens,
  output logic [1:0] winner,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = $clog2(POINT_PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POINT_PAUSE_CYCLES - 1);

  match_state_t state_q, state_d;
  logic [3:0]       lvl_prev_q, lvl_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       winner_q, winner_d;
  logic             ball_run_q, ball_run_d;
  logic             ball_hold_q, ball_hold_d;
  logic             paddle_en_q, paddle_en_d;

  logic [3:0] lvl_cur, edges;
  logic cmd_p, cmd_r, cmd_s, cmd_hit;
  logic start_ev, serve_ev, top_ev, bot_ev;
  logic clr_scores, inc_top, inc_bot;
  logic top_at_limit, bot_at_limit;

  always_comb begin
    lvl_cur    = {start, start_ball, score_top, score_bot};
    lvl_prev_d = lvl_cur;
    edges      = lvl_cur & ~lvl_prev_q;

    cmd_p   = cmd_valid && (cmd_data == CMD_PAUSE);
    cmd_r   = cmd_valid && (cmd_data == CMD_RESTART);
    cmd_s   = cmd_valid && (cmd_data == CMD_SERVE);
    cmd_hit = cmd_p || cmd_r || cmd_s;

    // A recognised command byte shadows a button edge arriving in the same cycle.
    start_ev = edges[3] && !cmd_hit;
    serve_ev = edges[2] && !cmd_hit;
    top_ev   = edges[1];
    bot_ev   = edges[0];

    state_d    = state_q;
    winner_d   = winner_q;
    clr_scores = 1'b0;
    inc_top    = 1'b0;
    inc_bot    = 1'b0;

    if (cmd_r) begin
      state_d    = ST_SERVE;
      clr_scores = 1'b1;
      winner_d   = WIN_NONE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_ev) state_d = ST_SERVE;
        ST_SERVE: if (cmd_s || serve_ev) state_d = ST_PLAY;
        ST_PLAY: begin
          if (cmd_p) begin
            state_d = ST_PAUSE;
          end else if (top_ev && bot_ev) begin
            state_d = ST_POINT;
          end else if (top_ev) begin
            inc_top = 1'b1;
            if (top_at_limit) begin
              state_d  = ST_OVER;
              winner_d = WIN_TOP;
            end else begin
              state_d = ST_POINT;
            end
          end else if (bot_ev) begin
            inc_bot = 1'b1;
            if (bot_at_limit) begin
              state_d  = ST_OVER;
              winner_d = WIN_BOT;
            end else begin
              state_d = ST_POINT;
            end
          end
        end
        ST_POINT: if (cnt_q == CNT_LAST) state_d = ST_SERVE;
        ST_PAUSE: if (cmd_p) state_d = ST_PLAY;
        ST_OVER: begin
          if (start_ev) begin
            state_d    = ST_SERVE;
            clr_scores = 1'b1;
            winner_d   = WIN_NONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Held at zero outside POINT, so every entry starts the pause from 0.
    cnt_d = (state_q == ST_POINT) ? cnt_q + CNT_W'(1) : '0;

    ball_run_d  = (state_d == ST_PLAY);
    paddle_en_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    ball_hold_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                  (state_d == ST_POINT) || (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lvl_prev_q  <= 4'd0;
      cnt_q       <= '0;
      winner_q    <= WIN_NONE;
      ball_run_q  <= 1'b0;
      ball_hold_q <= 1'b1;
      paddle_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_prev_q  <= lvl_prev_d;
      cnt_q       <= cnt_d;
      winner_q    <= winner_d;
      ball_run_q  <= ball_run_d;
      ball_hold_q <= ball_hold_d;
      paddle_en_q <= paddle_en_d;
    end
  end

  score_bcd_counter #(.LIMIT(WIN_SCORE)) u_top_score (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_scores),
    .inc      (inc_top),
    .ones     (top_ones),
    .tens     (top_tens),
    .at_limit (top_at_limit)
  );

  score_bcd_counter #(.LIMIT(WIN_SCORE)) u_bot_score (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_scores),
    .inc      (inc_bot),
    .ones     (bot_ones),
    .tens     (bot_tens),
    .at_limit (bot_at_limit)
  );

  assign ball_run  = ball_run_q;
  assign ball_hold = ball_hold_q;
  assign paddle_en = paddle_en_q;
  assign winner    = winner_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed and randomized bench for match_sequencer against a score/state reference model.
module tb_match_sequencer;
  import pong_pkg::*;

  localparam int WIN = 11;
  localparam int PP  = 4;

  logic       clk = 1'b0;
  logic       reset, start, start_ball, score_top, score_bot, cmd_valid;
  logic [7:0] cmd_data;
  logic       ball_run, ball_hold, paddle_en;
  logic [3:0] top_ones, top_tens, bot_ones, bot_tens;
  logic [1:0] winner;
  logic [2:0] state_dbg;

  int compared   = 0;
  int mismatched = 0;

  match_state_t m_st;
  int m_top, m_bot, m_win, m_left;
  bit p_start, p_sb, p_st, p_sbt;

  always #5 clk = ~clk;

  match_sequencer #(.WIN_SCORE(WIN), .POINT_PAUSE_CYCLES(PP)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ball(start_ball),
    .score_top(score_top), .score_bot(score_bot), .cmd_valid(cmd_valid),
    .cmd_data(cmd_data), .ball_run(ball_run), .ball_hold(ball_hold),
    .paddle_en(paddle_en), .top_ones(top_ones), .top_tens(top_tens),
    .bot_ones(bot_ones), .bot_tens(bot_tens), .winner(winner),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer scores, a countdown for the point pause, spec transition rules.
  task automatic model_step(input bit rn, s, b, t, bo, cv, input logic [7:0] cd);
    bit es, eb, et, ebo, is_p, is_r, is_s, hit;
    match_state_t nxt;
    if (!rn) begin
      m_st = ST_IDLE; m_top = 0; m_bot = 0; m_win = 0; m_left = 0;
      p_start = 0; p_sb = 0; p_st = 0; p_sbt = 0;
      return;
    end
    es = s && !p_start; eb = b && !p_sb; et = t && !p_st; ebo = bo && !p_sbt;
    is_p = cv && cd == 8'h70; is_r = cv && cd == 8'h72; is_s = cv && cd == 8'h73;
    hit = is_p || is_r || is_s;
    nxt = m_st;
    if (is_r) begin
      nxt = ST_SERVE; m_top = 0; m_bot = 0; m_win = 0;
    end else begin
      case (m_st)
        ST_IDLE:  if (es && !hit) nxt = ST_SERVE;
        ST_SERVE: if (is_s || (eb && !hit)) nxt = ST_PLAY;
        ST_PLAY: begin
          if (is_p) nxt = ST_PAUSE;
          else if (et && ebo) nxt = ST_POINT;
          else if (et) begin
            m_top++;
            if (m_top == WIN) begin nxt = ST_OVER; m_win = 1; end else nxt = ST_POINT;
          end else if (ebo) begin
            m_bot++;
            if (m_bot == WIN) begin nxt = ST_OVER; m_win = 2; end else nxt = ST_POINT;
          end
        end
        ST_POINT: begin
          m_left--;
          if (m_left == 0) nxt = ST_SERVE;
        end
        ST_PAUSE: if (is_p) nxt = ST_PLAY;
        ST_OVER: if (es && !hit) begin
          nxt = ST_SERVE; m_top = 0; m_bot = 0; m_win = 0;
        end
        default: nxt = ST_IDLE;
      endcase
    end
    if (nxt == ST_POINT && m_st != ST_POINT) m_left = PP;
    m_st = nxt;
    p_start = s; p_sb = b; p_st = t; p_sbt = bo;
  endtask

  task automatic check_all();
    chk("state", 8'(state_dbg), 8'(m_st));
    chk("ball_run", 8'(ball_run), 8'(m_st == ST_PLAY));
    chk("paddle_en", 8'(paddle_en), 8'(m_st == ST_SERVE || m_st == ST_PLAY));
    chk("ball_hold", 8'(ball_hold), 8'(m_st == ST_IDLE || m_st == ST_SERVE ||
                                        m_st == ST_POINT || m_st == ST_OVER));
    chk("top_ones", 8'(top_ones), 8'(m_top % 10));
    chk("top_tens", 8'(top_tens), 8'(m_top / 10));
    chk("bot_ones", 8'(bot_ones), 8'(m_bot % 10));
    chk("bot_tens", 8'(bot_tens), 8'(m_bot / 10));
    chk("winner", 8'(winner), 8'(m_win));
  endtask

  task automatic step(input bit rn, s, b, t, bo, cv, input logic [7:0] cd);
    reset = rn; start = s; start_ball = b; score_top = t; score_bot = bo;
    cmd_valid = cv; cmd_data = cd;
    @(posedge clk);
    model_step(rn, s, b, t, bo, cv, cd);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic cmd(input logic [7:0] c);
    step(1, 0, 0, 0, 0, 1, c);
  endtask

  // From SERVE: serve, score one point for the chosen side, wait out the pause.
  task automatic award(input bit to_top);
    cmd(CMD_SERVE);
    step(1, 0, 0, to_top, !to_top, 0, 8'h00);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    idle(PP);
  endtask

  initial begin
    bit s, b, t, bo, cv, rn;
    logic [7:0] cd;
    int sel;

    // Reset values
    step(0, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_state", 8'(state_dbg), 8'(ST_IDLE));
    chk("rst_hold", 8'(ball_hold), 8'd1);
    idle(2);

    // Start, serve, pause toggle
    step(1, 1, 0, 0, 0, 0, 8'h00);
    chk("start_serve", 8'(state_dbg), 8'(ST_SERVE));
    step(1, 0, 0, 0, 0, 0, 8'h00);
    cmd(CMD_SERVE);
    chk("serve_play", 8'(state_dbg), 8'(ST_PLAY));
    chk("serve_run", 8'(ball_run), 8'd1);
    cmd(CMD_PAUSE);
    chk("pause_on", 8'(state_dbg), 8'(ST_PAUSE));
    cmd(CMD_PAUSE);
    chk("pause_off", 8'(state_dbg), 8'(ST_PLAY));

    // Held score level gives one point, POINT lasts PP cycles
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0, 0, 8'h00);
    chk("held_top_ones", 8'(top_ones), 8'd1);
    chk("held_to_serve", 8'(state_dbg), 8'(ST_SERVE));
    step(1, 0, 0, 0, 0, 0, 8'h00);

    // Bottom carry and win
    for (int i = 0; i < 9; i++) award(0);
    chk("bot_nine", 8'(bot_ones), 8'd9);
    award(0);
    chk("carry_ones", 8'(bot_ones), 8'd0);
    chk("carry_tens", 8'(bot_tens), 8'd1);
    award(0);
    chk("win_ones", 8'(bot_ones), 8'd1);
    chk("win_state", 8'(state_dbg), 8'(ST_OVER));
    chk("win_who", 8'(winner), 8'(WIN_BOT));
    step(1, 1, 0, 0, 0, 0, 8'h00);
    chk("over_serve", 8'(state_dbg), 8'(ST_SERVE));
    chk("over_clr_bt", 8'(bot_tens), 8'd0);
    chk("over_clr_to", 8'(top_ones), 8'd0);
    chk("over_clr_win", 8'(winner), 8'(WIN_NONE));
    step(1, 0, 0, 0, 0, 0, 8'h00);

    // Simultaneous score edges
    cmd(CMD_SERVE);
    step(1, 0, 0, 1, 1, 0, 8'h00);
    chk("simul_state", 8'(state_dbg), 8'(ST_POINT));
    chk("simul_top", 8'(top_ones), 8'd0);
    chk("simul_bot", 8'(bot_ones), 8'd0);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    idle(PP);

    // Ignored score edges in SERVE and PAUSE
    step(1, 0, 0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 1, 0, 8'h00);
    chk("serve_ign", 8'(state_dbg), 8'(ST_SERVE));
    cmd(CMD_SERVE);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    cmd(CMD_PAUSE);
    step(1, 1, 1, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 1, 0, 8'h00);
    chk("pause_ign_st", 8'(state_dbg), 8'(ST_PAUSE));
    chk("pause_ign_sc", 8'(top_ones), 8'd0);
    cmd(CMD_PAUSE);
    cmd(CMD_RESTART);

    // Restart from PLAY at 3-5
    for (int i = 0; i < 3; i++) award(1);
    for (int i = 0; i < 5; i++) award(0);
    chk("pre_r_top", 8'(top_ones), 8'd3);
    cmd(CMD_SERVE);
    cmd(CMD_RESTART);
    chk("r_state", 8'(state_dbg), 8'(ST_SERVE));
    chk("r_bot", 8'(bot_ones), 8'd0);

    // Reset mid-POINT, then a full pause to confirm the counter restarted
    cmd(CMD_SERVE);
    step(1, 0, 0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    chk("midrst_state", 8'(state_dbg), 8'(ST_IDLE));
    chk("midrst_top", 8'(top_ones), 8'd0);
    step(1, 1, 0, 0, 0, 0, 8'h00);
    award(1);
    chk("post_rst_serve", 8'(state_dbg), 8'(ST_SERVE));

    // Randomized phase
    s = 0; b = 0; t = 0; bo = 0;
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) s = !s;
      if ($urandom_range(0, 4) == 0) b = !b;
      if ($urandom_range(0, 2) == 0) t = !t;
      if ($urandom_range(0, 2) == 0) bo = !bo;
      cv = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 15);
      if (sel == 0) cd = CMD_RESTART;
      else if (sel < 6) cd = CMD_PAUSE;
      else if (sel < 12) cd = CMD_SERVE;
      else cd = 8'($urandom_range(0, 255));
      step(rn, s, b, t, bo, cv, cd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
